exec_stage: RTL

- Execute pipeline stage wrapping the combinational `alu` (i_op/i_sz/i_src1/i_src2 -> o_dest).
- Accepts decoded, operand-read instructions from the register-read stage over a valid/ready handshake.
- Computes the result through `alu` and presents a registered result to writeback over a second valid/ready handshake.
- A 1-entry skid buffer keeps full throughput with a registered upstream ready.

---
 rtl/exec_pkg.sv | 48 ++++
 rtl/exec_stage_alu.sv | 25 ++
 rtl/exec_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage and its ALU.
package exec_pkg;

   // Field widths of the held entry; exec_stage parameters default to these
   // and must stay equal to them.
   localparam int REG_W = 5;
   localparam int TAG_W = 8;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   // One instruction result as held in the output register or skid entry.
   typedef struct packed {
      logic [63:0]      result;
      logic [REG_W-1:0] rd;
      logic             we;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } entry_t;

   // Pipe occupancy: nothing held, output only, output plus skid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b10
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   function automatic logic [63:0] size_mask(input logic [1:0] sz);
      logic [63:0] mask;
      case (sz)
         SZ_B:    mask = 64'h0000_0000_0000_00FF;
         SZ_H:    mask = 64'h0000_0000_0000_FFFF;
         SZ_W:    mask = 64'h0000_0000_FFFF_FFFF;
         default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/exec_stage_alu.sv
// Combinational add/sub ALU with size truncation and zero extension.
module alu
   import exec_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [1:0]  i_sz,
   input  logic [63:0] i_src1,
   input  logic [63:0] i_src2,
   output logic [63:0] o_dest
);

   logic [63:0] raw;

   // Full-width operation, then keep only the low bits of the operand size.
   always_comb begin
      raw = '0;
      case (i_op)
         OP_ADD:  raw = i_src1 + i_src2;
         OP_SUB:  raw = i_src1 - i_src2;
         default: raw = '0;
      endcase
      o_dest = raw & size_mask(i_sz);
   end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ALU plus a registered output and a one-entry skid buffer,
// so upstream ready can be a flop while throughput stays at one per cycle.
module exec_stage
   import exec_pkg::*;
#(
   parameter int REG_BITS = REG_W,
   parameter int TAG_BITS = TAG_W
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [3:0]          i_op,
   input  logic [1:0]          i_sz,
   input  logic [63:0]         i_src1,
   input  logic [63:0]         i_src2,
   input  logic [REG_BITS-1:0] i_rd,
   input  logic [TAG_BITS-1:0] i_tag,
   input  logic                i_flush,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [63:0]         o_result,
   output logic [REG_BITS-1:0] o_rd,
   output logic                o_we,
   output logic                o_illegal,
   output logic [TAG_BITS-1:0] o_tag
);

   state_t      state;
   state_t      state_next;
   entry_t      out_q;
   entry_t      skid_q;
   entry_t      incoming;
   logic [63:0] alu_dest;
   logic        accept;
   logic        load_out_in;
   logic        load_out_skid;
   logic        load_skid;

   alu u_alu (
      .i_op   (i_op),
      .i_sz   (i_sz),
      .i_src1 (i_src1),
      .i_src2 (i_src2),
      .o_dest (alu_dest)
   );

   // Ready depends only on the state flop, never on i_ready.
   assign o_ready = (state != ST_FULL);
   assign o_valid = (state != ST_EMPTY);
   assign accept  = i_valid && o_ready && !i_flush;

   // Package the incoming instruction as it would be held.
   always_comb begin
      incoming.result  = alu_dest;
      incoming.rd      = i_rd;
      incoming.illegal = !op_legal(i_op);
      incoming.we      = (i_rd != '0) && op_legal(i_op);
      incoming.tag     = i_tag;
   end

   // Occupancy transitions and which register loads from where.
   always_comb begin
      state_next    = state;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      if (i_flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state_next  = ST_ONE;
                  load_out_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (i_ready) begin
                  if (accept) begin
                     load_out_in = 1'b1;
                  end else begin
                     state_next = ST_EMPTY;
                  end
               end else if (accept) begin
                  state_next = ST_FULL;
                  load_skid  = 1'b1;
               end
            end
            ST_FULL: begin
               if (i_ready) begin
                  state_next    = ST_ONE;
                  load_out_skid = 1'b1;
               end
            end
            default: state_next = ST_EMPTY;
         endcase
      end
   end

   // State register; reset drops everything held.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Output and skid data registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out_in) begin
            out_q <= incoming;
         end else if (load_out_skid) begin
            out_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= incoming;
         end
      end
   end

   assign o_result  = out_q.result;
   assign o_rd      = out_q.rd;
   assign o_we      = out_q.we;
   assign o_illegal = out_q.illegal;
   assign o_tag     = out_q.tag;

endmodule
